// File: rtl/return_addr_stack_pkg.sv
// Shared PC-width defaults and types for the PC-source mux and the return-address stack.
package return_addr_stack_pkg;

    localparam int PC_LEN_DEF    = 12;
    localparam int RAS_DEPTH_DEF = 8;

    typedef logic [PC_LEN_DEF-1:0] pc_t;

    // Encoding matches the {push, pop} pair so the request can be cast directly.
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_REPL = 2'b11
    } ras_op_e;

endpackage

// File: rtl/return_addr_stack_ras_storage.sv
// DEPTH x W register array: one synchronous write port and one combinational read port.
module ras_storage #(
    parameter int W     = 12,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // The stack only ever presents in-range addresses.
    assign rdata = mem[raddr];

endmodule

// File: rtl/return_addr_stack.sv
// Return-address stack driven by the EX-stage push/pop pair; stalls and flushes squash
// requests so only committed-path calls/returns touch the stack.
module return_addr_stack
    import return_addr_stack_pkg::*;
#(
    parameter  int PC_LEN = PC_LEN_DEF,
    parameter  int DEPTH  = RAS_DEPTH_DEF,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [PC_LEN-1:0] push_data,
    input  logic              clear_err,
    output logic [PC_LEN-1:0] top_data,
    output logic              empty,
    output logic              full,
    output logic [CNT_W-1:0]  count,
    output logic              overflow_err,
    output logic              underflow_err
);

    localparam int AW = $clog2(DEPTH);

    logic              op_ok;
    ras_op_e           op;
    logic [CNT_W-1:0]  count_nxt;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [AW-1:0]     top_idx;
    logic [AW-1:0]     rd_addr;
    logic [PC_LEN-1:0] rd_data;
    logic              ovf_set;
    logic              unf_set;

    assign op_ok = en & ~flush;
    assign op    = ras_op_e'({push, pop});
    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

    // Low bits of count are zero only when count == DEPTH == 2**AW, where -1 still lands on DEPTH-1.
    assign top_idx = count[AW-1:0] - AW'(1);
    assign rd_addr = empty ? '0 : top_idx;

    always_comb begin
        count_nxt = count;
        wr_en     = 1'b0;
        wr_addr   = count[AW-1:0];
        ovf_set   = 1'b0;
        unf_set   = 1'b0;
        if (op_ok) begin
            unique case (op)
                OP_PUSH: begin
                    if (full) ovf_set = 1'b1;
                    else begin
                        wr_en     = 1'b1;
                        count_nxt = count + CNT_W'(1);
                    end
                end
                OP_POP: begin
                    if (empty) unf_set = 1'b1;
                    else count_nxt = count - CNT_W'(1);
                end
                OP_REPL: begin
                    wr_en = 1'b1;
                    if (empty) begin
                        unf_set   = 1'b1;
                        count_nxt = CNT_W'(1);
                    end else begin
                        wr_addr = top_idx;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count         <= '0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            count         <= count_nxt;
            overflow_err  <= ovf_set | (overflow_err & ~clear_err);
            underflow_err <= unf_set | (underflow_err & ~clear_err);
        end
    end

    ras_storage #(.W(PC_LEN), .DEPTH(DEPTH), .AW(AW)) u_storage (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (push_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    assign top_data = empty ? '0 : rd_data;

endmodule
